// File: rtl/chacha20_stream_ctrl.sv
// Job sequencer for a single-block ChaCha20 core: accepts one job descriptor, streams
// plaintext blocks through the core one at a time and returns ciphertext in order.
module chacha20_stream_ctrl #(
  parameter int NB_W    = 16,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [255:0]    cfg_key,
  input  logic [95:0]     cfg_nonce,
  input  logic [31:0]     cfg_counter,
  input  logic [NB_W-1:0] cfg_nblocks,
  input  logic            pt_valid,
  output logic            pt_ready,
  input  logic [511:0]    pt_data,
  output logic            ct_valid,
  input  logic            ct_ready,
  output logic [511:0]    ct_data,
  output logic            ct_last,
  output logic [255:0]    core_key,
  output logic [95:0]     core_nonce,
  output logic [31:0]     core_counter,
  output logic [511:0]    core_plaintext,
  output logic            core_start,
  input  logic            core_done,
  input  logic [511:0]    core_ciphertext,
  output logic            busy,
  output logic            err_ctr_wrap,
  output logic            err_timeout
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, WAIT_PT, START, RUN, OUT} state_t;

  state_t          state, state_nx;
  logic [NB_W-1:0] remaining;
  logic [WD_W-1:0] wd;
  logic            cfg_hs, pt_hs, last_blk, wd_expired;

  assign cfg_hs     = cfg_valid && (state == IDLE);
  assign pt_hs      = pt_valid && (state == WAIT_PT);
  assign last_blk   = (remaining == NB_W'(1));
  assign wd_expired = (wd == WD_W'(TIMEOUT - 1)) && !core_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    cfg_ready  = 1'b0;
    pt_ready   = 1'b0;
    core_start = 1'b0;
    ct_valid   = 1'b0;
    busy       = (state != IDLE);
    case (state)
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_hs && (cfg_nblocks != '0)) state_nx = WAIT_PT;
      end
      WAIT_PT: begin
        pt_ready = 1'b1;
        if (pt_hs) state_nx = START;
      end
      START: begin
        core_start = 1'b1;
        state_nx   = RUN;
      end
      RUN: begin
        if (core_done)       state_nx = OUT;
        else if (wd_expired) state_nx = IDLE;
      end
      OUT: begin
        ct_valid = 1'b1;
        if (ct_ready) state_nx = last_blk ? IDLE : WAIT_PT;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      core_key       <= '0;
      core_nonce     <= '0;
      core_counter   <= '0;
      core_plaintext <= '0;
      ct_data        <= '0;
      ct_last        <= 1'b0;
      remaining      <= '0;
      wd             <= '0;
      err_ctr_wrap   <= 1'b0;
      err_timeout    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (cfg_hs) begin
          core_key     <= cfg_key;
          core_nonce   <= cfg_nonce;
          core_counter <= cfg_counter;
          remaining    <= cfg_nblocks;
          err_ctr_wrap <= 1'b0;
          err_timeout  <= 1'b0;
        end
        WAIT_PT: if (pt_hs) core_plaintext <= pt_data;
        START: wd <= '0;
        RUN: begin
          if (core_done) begin
            ct_data <= core_ciphertext;
            ct_last <= last_blk;
          end else if (wd_expired) begin
            err_timeout <= 1'b1;
          end else begin
            wd <= wd + WD_W'(1);
          end
        end
        OUT: if (ct_ready) begin
          // counter only wraps into a live block if more blocks follow
          core_counter <= core_counter + 32'd1;
          remaining    <= remaining - NB_W'(1);
          if ((core_counter == 32'hFFFF_FFFF) && !last_blk) err_ctr_wrap <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
